// File: rtl/int_to_fp32.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single-precision converter,
// round-to-nearest-even, with one-bit-per-cycle normalization.
module int_to_fp32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fp,
  output logic        out_inexact
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nx;
  logic        sign;
  logic [31:0] mag;
  logic [7:0]  exp;

  logic [22:0] frac;
  logic        g, s, roundup;
  logic [23:0] frac_sum;
  logic [7:0]  exp_r;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Once mag[31] is set, mag[30:8] is the fraction and mag[7:0] the discarded tail.
  always_comb begin
    frac     = mag[30:8];
    g        = mag[7];
    s        = |mag[6:0];
    roundup  = g & (s | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, roundup};
    // A carry out leaves frac_sum[22:0] at zero, so only the exponent moves.
    exp_r    = exp + {7'd0, frac_sum[23]};
  end

  // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = (in_int == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign        <= 1'b0;
      mag         <= 32'd0;
      exp         <= 8'd0;
      out_fp      <= 32'd0;
      out_inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_int[31];
            mag  <= in_int[31] ? (~in_int + 32'd1) : in_int;
            exp  <= 8'd158;
            if (in_int == 32'd0) begin
              out_fp      <= 32'd0;
              out_inexact <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!mag[31]) begin
            mag <= {mag[30:0], 1'b0};
            exp <= exp - 8'd1;
          end
        end
        ROUND: begin
          out_fp      <= {sign, exp_r, frac_sum[22:0]};
          out_inexact <= g | s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp32.sv
// Self-checking bench for int_to_fp32: directed corner values, randomized
// operands against an arithmetic reference model, backpressure and reset.
module tb_int_to_fp32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_int = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_fp;
  logic        out_inexact;

  int vectors     = 0;
  int miscompares = 0;

  int_to_fp32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: locate the top set bit, keep 24 significant bits, round the
  // remainder against half an ulp with ties going to the even significand.
  function automatic void model(input logic [31:0] x, output logic [31:0] fp,
                                output logic inx, output int lat);
    longint unsigned m, q, rem, half;
    int p, sh;
    logic sgn;
    sgn = x[31];
    m   = sgn ? ((64'd1 << 32) - {32'd0, x}) : {32'd0, x};
    fp  = 32'd0;
    inx = 1'b0;
    lat = 1;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = (31 - p) + 3;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    fp = {sgn, 8'(127 + p), q[22:0]};
  endfunction

  // Called on the falling edge after the accept edge; counts edges until out_valid.
  task automatic wait_out(output int lat, output bit timeout);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    timeout = !out_valid;
  endtask

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_op(input logic [31:0] x, input logic [31:0] efp,
                        input logic einx, input int elat, input string name);
    int lat;
    bit to;
    in_int    = x;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL %s timeout: out_valid never rose", name);
    end else begin
      vectors += 3;
      if (lat != elat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
      end
      if (out_fp !== efp) begin
        miscompares++;
        $display("FAIL %s out_fp (in %h): got %h want %h", name, x, out_fp, efp);
      end
      if (out_inexact !== einx) begin
        miscompares++;
        $display("FAIL %s out_inexact (in %h): got %b want %b", name, x, out_inexact, einx);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s return to idle: got valid=%b ready=%b want valid=0 ready=1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fp !== 32'd0 || out_inexact !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state: got ready=%b valid=%b fp=%h inx=%b want 1 0 00000000 0",
               in_ready, out_valid, out_fp, out_inexact);
    end
  endtask

  task automatic test_directed();
    run_op(32'd1,          32'h3F800000, 1'b0, 34, "one");
    run_op(32'hFFFFFFFF,   32'hBF800000, 1'b0, 34, "minus_one");
    run_op(32'd0,          32'h00000000, 1'b0, 1,  "zero");
    run_op(32'h80000000,   32'hCF000000, 1'b0, 3,  "int_min");
    run_op(32'h7FFFFFFF,   32'h4F000000, 1'b1, 4,  "round_carry");
    run_op(32'd16777217,   32'h4B800000, 1'b1, 10, "tie_down");
    run_op(32'd16777219,   32'h4B800002, 1'b1, 10, "tie_up");
    run_op(32'd16777218,   32'h4B800001, 1'b0, 10, "exact_odd");
  endtask

  // Consecutive operations: each accept lands in the IDLE cycle after DONE.
  task automatic test_back_to_back();
    logic [31:0] x, efp;
    logic einx;
    int elat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      model(x, efp, einx, elat);
      run_op(x, efp, einx, elat, "random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    logic [31:0] efp;
    logic einx;
    int elat;
    in_int    = 32'd100;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_int = 32'd7;
    wait_out(lat, to);
    vectors++;
    if (to || out_fp !== 32'h42C80000 || lat != 28) begin
      miscompares++;
      $display("FAIL bp first result: got fp=%h lat=%0d timeout=%b want 42c80000 28 0",
               out_fp, lat, to);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_fp !== 32'h42C80000 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp hold cycle %0d: got valid=%b fp=%h ready=%b want 1 42c80000 0",
                 i, out_valid, out_fp, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    model(32'd7, efp, einx, elat);
    wait_out(lat, to);
    vectors++;
    if (to || out_fp !== 32'h40E00000 || out_fp !== efp || lat != elat) begin
      miscompares++;
      $display("FAIL bp second result: got fp=%h lat=%0d want 40e00000 %0d", out_fp, lat, elat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    logic [31:0] efp;
    logic einx;
    int elat;
    in_int   = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_fp !== 32'd0 || out_inexact !== 1'b0) begin
      miscompares++;
      $display("FAIL reset mid-norm: got valid=%b ready=%b fp=%h inx=%b want 0 1 00000000 0",
               out_valid, in_ready, out_fp, out_inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL reset discard: got out_valid pulse after reset want none");
    end
    model(32'hFFFFFFFA, efp, einx, elat);
    run_op(32'hFFFFFFFA, 32'hC0C00000, 1'b0, elat, "after_reset");
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
